fpu_pipe: RTL and testbench



---
 rtl/fpu_pkg.sv | 68 ++++++
 rtl/fp_lzc.sv | 25 ++
 rtl/fpu_pipe.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_fpu_pipe.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the pipelined floating-point adder.
//   - flag bit positions inside the 3-bit {invalid, overflow, inexact} vector
//   - operand special-class enum
//   - canonical quiet-NaN and field-extract helpers; widths are passed in as
//     arguments so one copy serves every EXP_W/MAN_W build (operands <= 64 bits)
package fpu_pkg;

  localparam int unsigned FLG_INV  = 2;
  localparam int unsigned FLG_OVF  = 1;
  localparam int unsigned FLG_INX  = 0;
  localparam int unsigned FP_MAX_W = 64;

  typedef enum logic [2:0] {
    NORMAL,
    ZERO,
    INF,
    QNAN,
    SNAN
  } fp_class_e;

  // {0, all-ones exponent, 1 followed by zeros}, right-aligned in 64 bits
  function automatic logic [FP_MAX_W-1:0] fp_canon_nan(input int unsigned exp_w,
                                                       input int unsigned man_w);
    logic [FP_MAX_W-1:0] one;
    one = FP_MAX_W'(1);
    return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_field_exp(input logic [FP_MAX_W-1:0] x,
                                                       input int unsigned exp_w,
                                                       input int unsigned man_w);
    logic [FP_MAX_W-1:0] one;
    one = FP_MAX_W'(1);
    return (x >> man_w) & ((one << exp_w) - one);
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_field_frac(input logic [FP_MAX_W-1:0] x,
                                                        input int unsigned man_w);
    logic [FP_MAX_W-1:0] one;
    one = FP_MAX_W'(1);
    return x & ((one << man_w) - one);
  endfunction

  function automatic logic fp_field_sign(input logic [FP_MAX_W-1:0] x,
                                         input int unsigned exp_w,
                                         input int unsigned man_w);
    logic [FP_MAX_W-1:0] t;
    t = x >> (exp_w + man_w);
    return t[0];
  endfunction

  // Subnormals (exp == 0, frac != 0) classify as ZERO: the unit flushes them.
  function automatic fp_class_e fp_classify(input logic exp_ones, input logic exp_zero,
                                            input logic frac_zero, input logic frac_msb);
    fp_class_e c;
    if (exp_ones) begin
      if (frac_zero)     c = INF;
      else if (frac_msb) c = QNAN;
      else               c = SNAN;
    end else if (exp_zero) begin
      c = ZERO;
    end else begin
      c = NORMAL;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter.
//   in_vec : WIDTH-bit input, MSB first
//   cnt    : number of zeros above the most significant one (WIDTH if all zero)
module fp_lzc #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_vec,
  output logic [CNT_W-1:0] cnt
);

  logic found;

  always_comb begin
    cnt   = CNT_W'(WIDTH);
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && in_vec[WIDTH-1-i]) begin
        cnt   = CNT_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_pipe.sv
// fpu_pipe: 3-stage pipelined IEEE-754 add/subtract, round-to-nearest-even,
// subnormals flushed to zero.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, op; op=1 computes a-b)
//   out_valid/out_ready : result handshake (result, flags)
//   flags               : {invalid, overflow, inexact}, meaningful with out_valid
// Stages: S1 unpack/special-case/swap/align, S2 significand add, S3 normalise
// and round. A single global advance stalls every stage together.
module fpu_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W    = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [2:0]   flags
);

  localparam int unsigned MAG_W = EXP_W + MAN_W;
  localparam int unsigned SIG_W = MAN_W + 4;        // hidden + frac + guard/round/sticky
  localparam int unsigned SUM_W = MAN_W + 5;        // plus carry-out
  localparam int unsigned LZ_W  = $clog2(SIG_W + 1);
  localparam int unsigned XE_W  = EXP_W + 2;        // room for carry and negative underflow
  localparam int unsigned MR_W  = MAN_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] SH_MAX   = EXP_W'(MAN_W + 3);
  localparam logic [W-1:0]     QNAN_W   = W'(fp_canon_nan(EXP_W, MAN_W));
  localparam logic [SIG_W-1:0] SIG_ONE  = SIG_W'(1);

  logic advance;

  // ---------------- S1 combinational: unpack, specials, swap, align
  logic [FP_MAX_W-1:0] a_ext, b_ext;
  logic [EXP_W-1:0]    ea, eb, e_big, e_small, d;
  logic [MAN_W-1:0]    fa, fb;
  logic                sa, sb, swap, s_big, s_small;
  fp_class_e           cls_a, cls_b;
  logic [MAG_W-1:0]    mag_a, mag_b, mag_big, mag_small;
  logic [SIG_W-1:0]    sig_big, sig_small, sig_sh, lost;
  logic                spec;
  logic [W-1:0]        spec_res;
  logic [2:0]          spec_flg;

  always_comb begin
    a_ext    = FP_MAX_W'(a);
    b_ext    = FP_MAX_W'(b);
    ea       = EXP_W'(fp_field_exp(a_ext, EXP_W, MAN_W));
    eb       = EXP_W'(fp_field_exp(b_ext, EXP_W, MAN_W));
    fa       = MAN_W'(fp_field_frac(a_ext, MAN_W));
    fb       = MAN_W'(fp_field_frac(b_ext, MAN_W));
    sa       = fp_field_sign(a_ext, EXP_W, MAN_W);
    sb       = fp_field_sign(b_ext, EXP_W, MAN_W) ^ op;
    cls_a    = fp_classify(ea == EXP_ONES, ea == '0, fa == '0, fa[MAN_W-1]);
    cls_b    = fp_classify(eb == EXP_ONES, eb == '0, fb == '0, fb[MAN_W-1]);

    spec     = 1'b0;
    spec_res = '0;
    spec_flg = '0;
    if (cls_a == QNAN || cls_a == SNAN || cls_b == QNAN || cls_b == SNAN) begin
      spec              = 1'b1;
      spec_res          = QNAN_W;
      spec_flg[FLG_INV] = (cls_a == SNAN) || (cls_b == SNAN);
    end else if (cls_a == INF && cls_b == INF) begin
      spec = 1'b1;
      if (sa != sb) begin
        spec_res          = QNAN_W;
        spec_flg[FLG_INV] = 1'b1;
      end else begin
        spec_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
      end
    end else if (cls_a == INF) begin
      spec     = 1'b1;
      spec_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
    end else if (cls_b == INF) begin
      spec     = 1'b1;
      spec_res = {sb, EXP_ONES, {MAN_W{1'b0}}};
    end else if (cls_a == ZERO && cls_b == ZERO) begin
      // only (-0)+(-0) keeps a negative sign under RNE
      spec     = 1'b1;
      spec_res = {sa & sb, {(W-1){1'b0}}};
    end

    // flushed magnitudes: a subnormal compares and aligns as exactly zero
    mag_a     = (cls_a == ZERO) ? '0 : {ea, fa};
    mag_b     = (cls_b == ZERO) ? '0 : {eb, fb};
    swap      = mag_b > mag_a;
    mag_big   = swap ? mag_b : mag_a;
    mag_small = swap ? mag_a : mag_b;
    s_big     = swap ? sb : sa;
    s_small   = swap ? sa : sb;
    e_big     = mag_big[MAG_W-1:MAN_W];
    e_small   = mag_small[MAG_W-1:MAN_W];
    sig_big   = {|e_big, mag_big[MAN_W-1:0], 3'b000};
    sig_small = {|e_small, mag_small[MAN_W-1:0], 3'b000};
    d         = e_big - e_small;

    lost   = '0;
    sig_sh = '0;
    if (d >= SH_MAX) begin
      sig_sh[0] = |sig_small;
    end else begin
      sig_sh    = sig_small >> d;
      lost      = sig_small & ((SIG_ONE << d) - SIG_ONE);
      sig_sh[0] = sig_sh[0] | (|lost);
    end
  end

  // ---------------- pipeline registers
  logic             s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d, s1_sub_q, s1_sub_d;
  logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
  logic [SIG_W-1:0] s1_big_q, s1_big_d, s1_small_q, s1_small_d;
  logic             s1_spec_q, s1_spec_d;
  logic [W-1:0]     s1_sres_q, s1_sres_d;
  logic [2:0]       s1_sflg_q, s1_sflg_d;

  logic             s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d;
  logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
  logic [SUM_W-1:0] s2_sum_q, s2_sum_d;
  logic             s2_spec_q, s2_spec_d;
  logic [W-1:0]     s2_sres_q, s2_sres_d;
  logic [2:0]       s2_sflg_q, s2_sflg_d;

  logic             s3_valid_q, s3_valid_d;
  logic [W-1:0]     res_q, res_d;
  logic [2:0]       flg_q, flg_d;

  assign advance   = !s3_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = s3_valid_q;
  assign result    = res_q;
  assign flags     = flg_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_sub_d   = s1_sub_q;
    s1_exp_d   = s1_exp_q;
    s1_big_d   = s1_big_q;
    s1_small_d = s1_small_q;
    s1_spec_d  = s1_spec_q;
    s1_sres_d  = s1_sres_q;
    s1_sflg_d  = s1_sflg_q;
    if (advance) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d  = s_big;
        s1_sub_d   = s_big ^ s_small;
        s1_exp_d   = e_big;
        s1_big_d   = sig_big;
        s1_small_d = sig_sh;
        s1_spec_d  = spec;
        s1_sres_d  = spec_res;
        s1_sflg_d  = spec_flg;
      end
    end
  end

  // ---------------- S2: significand add/subtract (|big| >= |small|, never negative)
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_exp_d   = s2_exp_q;
    s2_sum_d   = s2_sum_q;
    s2_spec_d  = s2_spec_q;
    s2_sres_d  = s2_sres_q;
    s2_sflg_d  = s2_sflg_q;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_d = s1_sign_q;
        s2_exp_d  = s1_exp_q;
        s2_sum_d  = s1_sub_q ? ({1'b0, s1_big_q} - {1'b0, s1_small_q})
                             : ({1'b0, s1_big_q} + {1'b0, s1_small_q});
        s2_spec_d = s1_spec_q;
        s2_sres_d = s1_sres_q;
        s2_sflg_d = s1_sflg_q;
      end
    end
  end

  // ---------------- S3: normalise, round to nearest even, pack
  logic [LZ_W-1:0]  lz;
  logic [SIG_W-1:0] norm;
  logic [XE_W-1:0]  exp_n, exp_f;
  logic [MAN_W:0]   mant;
  logic [MR_W-1:0]  mant_r;
  logic [MAN_W-1:0] frac_f;
  logic             g, r, st, rnd_up, inexact;
  logic [W-1:0]     calc_res;
  logic [2:0]       calc_flg;

  fp_lzc #(.WIDTH(SIG_W), .CNT_W(LZ_W)) u_lzc (
    .in_vec (s2_sum_q[SIG_W-1:0]),
    .cnt    (lz)
  );

  always_comb begin
    if (s2_sum_q[SUM_W-1]) begin
      // carry-out: shift right one, folding the dropped bit into sticky
      norm  = {s2_sum_q[SUM_W-1:2], s2_sum_q[1] | s2_sum_q[0]};
      exp_n = {2'b00, s2_exp_q} + XE_W'(1);
    end else begin
      norm  = s2_sum_q[SIG_W-1:0] << lz;
      exp_n = {2'b00, s2_exp_q} - XE_W'(lz);
    end
    mant    = norm[SIG_W-1:3];
    g       = norm[2];
    r       = norm[1];
    st      = norm[0];
    inexact = g | r | st;
    rnd_up  = g & (r | st | mant[0]);
    mant_r  = {1'b0, mant} + MR_W'(rnd_up);
    // a rounding carry leaves 10..0; the stored fraction is then all zero
    exp_f   = exp_n + XE_W'(mant_r[MAN_W+1]);
    frac_f  = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];

    calc_res = {s2_sign_q, exp_f[EXP_W-1:0], frac_f};
    calc_flg = '0;
    calc_flg[FLG_INX] = inexact;
    if (s2_sum_q == '0) begin
      calc_res = '0;
      calc_flg = '0;
    end else if (exp_n[XE_W-1] || exp_n == '0) begin
      calc_res          = {s2_sign_q, {(W-1){1'b0}}};
      calc_flg          = '0;
      calc_flg[FLG_INX] = 1'b1;
    end else if (exp_f >= {2'b00, EXP_ONES}) begin
      calc_res          = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
      calc_flg          = '0;
      calc_flg[FLG_OVF] = 1'b1;
      calc_flg[FLG_INX] = 1'b1;
    end
  end

  always_comb begin
    s3_valid_d = s3_valid_q;
    res_d      = res_q;
    flg_d      = flg_q;
    if (advance) begin
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        res_d = s2_spec_q ? s2_sres_q : calc_res;
        flg_d = s2_spec_q ? s2_sflg_q : calc_flg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_sub_q   <= 1'b0;
      s1_exp_q   <= '0;
      s1_big_q   <= '0;
      s1_small_q <= '0;
      s1_spec_q  <= 1'b0;
      s1_sres_q  <= '0;
      s1_sflg_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_sum_q   <= '0;
      s2_spec_q  <= 1'b0;
      s2_sres_q  <= '0;
      s2_sflg_q  <= '0;
      s3_valid_q <= 1'b0;
      res_q      <= '0;
      flg_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_sub_q   <= s1_sub_d;
      s1_exp_q   <= s1_exp_d;
      s1_big_q   <= s1_big_d;
      s1_small_q <= s1_small_d;
      s1_spec_q  <= s1_spec_d;
      s1_sres_q  <= s1_sres_d;
      s1_sflg_q  <= s1_sflg_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_exp_q   <= s2_exp_d;
      s2_sum_q   <= s2_sum_d;
      s2_spec_q  <= s2_spec_d;
      s2_sres_q  <= s2_sres_d;
      s2_sflg_q  <= s2_sflg_d;
      s3_valid_q <= s3_valid_d;
      res_q      <= res_d;
      flg_q      <= flg_d;
    end
  end

endmodule

// File: tb/tb_fpu_pipe.sv
module tb_fpu_pipe;

  logic        clk, rst_n;
  logic        in_valid, in_ready, op, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [2:0]  flags;

  logic        d_in_valid, d_in_ready, d_op, d_out_valid, d_out_ready;
  logic [63:0] d_a, d_b, d_result;
  logic [2:0]  d_flags;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [2:0]  flg;
    string       name;
  } vec_t;

  fpu_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  fpu_pipe #(.EXP_W(11), .MAN_W(52)) dut_dp (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .a(d_a), .b(d_b), .op(d_op), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .result(d_result), .flags(d_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one operation and wait (bounded) for its result; lat reaches 10 on timeout.
  task automatic send_and_wait(input logic [31:0] ta, input logic [31:0] tb,
                               input logic top, output logic [31:0] res,
                               output logic [2:0] flg, output int lat);
    logic got;
    got = 1'b0;
    res = '0;
    flg = '0;
    lat = 0;
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb; op = top;
    @(posedge clk);
    #1 in_valid = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        got = 1'b1;
        res = result;
        flg = flags;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b1;
    d_in_valid = 1'b0; d_a = '0; d_b = '0; d_op = 1'b0; d_out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    n_checks++;
    if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h, expected 00000000", result); end
    n_checks++;
    if (flags !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b, expected 000", flags); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    n_checks++;
    if (d_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dp_out_valid: got %b, expected 0", d_out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_basic;
    vec_t v[3];
    logic [31:0] r; logic [2:0] f; int lat;
    v[0] = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, "1p0_plus_2p0"};
    v[1] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, "3p0_minus_1p0"};
    v[2] = '{32'hBF800000, 32'hC0000000, 1'b0, 32'hC0400000, 3'b000, "neg1_plus_neg2"};
    for (int i = 0; i < 3; i++) begin
      send_and_wait(v[i].a, v[i].b, v[i].op, r, f, lat);
      n_checks++;
      if (lat !== 3) begin n_fail++; $display("FAIL %s latency: got %0d, expected 3", v[i].name, lat); end
      n_checks++;
      if (r !== v[i].res) begin n_fail++; $display("FAIL %s result: got %h, expected %h", v[i].name, r, v[i].res); end
      n_checks++;
      if (f !== v[i].flg) begin n_fail++; $display("FAIL %s flags: got %b, expected %b", v[i].name, f, v[i].flg); end
    end
  endtask

  task automatic test_zero_results;
    vec_t v[6];
    logic [31:0] r; logic [2:0] f; int lat;
    v[0] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, "cancel_pos"};
    v[1] = '{32'hBF800000, 32'hBF800000, 1'b1, 32'h00000000, 3'b000, "cancel_neg"};
    v[2] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, "negz_plus_negz"};
    v[3] = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000, "posz_plus_negz"};
    v[4] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000, "subnormal_flush_in"};
    v[5] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b001, "underflow_flush"};
    for (int i = 0; i < 6; i++) begin
      send_and_wait(v[i].a, v[i].b, v[i].op, r, f, lat);
      n_checks++;
      if (r !== v[i].res) begin n_fail++; $display("FAIL %s result: got %h, expected %h", v[i].name, r, v[i].res); end
      n_checks++;
      if (f !== v[i].flg) begin n_fail++; $display("FAIL %s flags: got %b, expected %b", v[i].name, f, v[i].flg); end
    end
  endtask

  task automatic test_specials;
    vec_t v[6];
    logic [31:0] r; logic [2:0] f; int lat;
    v[0] = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100, "inf_plus_neginf"};
    v[1] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100, "inf_minus_inf"};
    v[2] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100, "snan_in"};
    v[3] = '{32'h3F800000, 32'hFFC00123, 1'b0, 32'h7FC00000, 3'b000, "qnan_in"};
    v[4] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000, "neginf_plus_fin"};
    v[5] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000, "fin_minus_inf"};
    for (int i = 0; i < 6; i++) begin
      send_and_wait(v[i].a, v[i].b, v[i].op, r, f, lat);
      n_checks++;
      if (r !== v[i].res) begin n_fail++; $display("FAIL %s result: got %h, expected %h", v[i].name, r, v[i].res); end
      n_checks++;
      if (f !== v[i].flg) begin n_fail++; $display("FAIL %s flags: got %b, expected %b", v[i].name, f, v[i].flg); end
    end
  endtask

  task automatic test_overflow;
    vec_t v[2];
    logic [31:0] r; logic [2:0] f; int lat;
    v[0] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011, "max_plus_max"};
    v[1] = '{32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1, 32'hFF800000, 3'b011, "negmax_minus_max"};
    for (int i = 0; i < 2; i++) begin
      send_and_wait(v[i].a, v[i].b, v[i].op, r, f, lat);
      n_checks++;
      if (r !== v[i].res) begin n_fail++; $display("FAIL %s result: got %h, expected %h", v[i].name, r, v[i].res); end
      n_checks++;
      if (f !== v[i].flg) begin n_fail++; $display("FAIL %s flags: got %b, expected %b", v[i].name, f, v[i].flg); end
    end
  endtask

  task automatic test_rounding;
    vec_t v[7];
    logic [31:0] r; logic [2:0] f; int lat;
    v[0] = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, "tie_to_even_down"};
    v[1] = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b001, "above_half_up"};
    v[2] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001, "tie_to_even_up"};
    v[3] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 3'b001, "round_carry_renorm"};
    v[4] = '{32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, 3'b000, "exact_one_ulp"};
    v[5] = '{32'h3F800000, 32'h33000000, 1'b1, 32'h3F800000, 3'b001, "sub_norm_tie_up"};
    v[6] = '{32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 3'b001, "far_shift_sticky"};
    for (int i = 0; i < 7; i++) begin
      send_and_wait(v[i].a, v[i].b, v[i].op, r, f, lat);
      n_checks++;
      if (r !== v[i].res) begin n_fail++; $display("FAIL %s result: got %h, expected %h", v[i].name, r, v[i].res); end
      n_checks++;
      if (f !== v[i].flg) begin n_fail++; $display("FAIL %s flags: got %b, expected %b", v[i].name, f, v[i].flg); end
    end
  endtask

  // Five adds issued back to back; out_ready low in cycles 4..7.
  // First result shows at cycle 3; the 5th operand is held off until cycle 8.
  task automatic test_back_to_back;
    logic [31:0] ins  [5];
    logic [31:0] exps [5];
    int sent, got;
    ins  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    exps = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    sent = 0;
    got  = 0;
    @(negedge clk);
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 4 && c <= 7);
      if (sent < 5) begin
        in_valid = 1'b1; a = ins[sent]; b = 32'h3F800000; op = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 3) begin
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_out_cycle3: got %b, expected 1", out_valid); end
      end
      if (c >= 4 && c <= 7) begin
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready_stall c%0d: got %b, expected 0", c, in_ready); end
      end
      if (c == 8) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_resume: got %b, expected 1", in_ready); end
      end
      if (out_valid && out_ready) begin
        if (got < 5) begin
          n_checks++;
          if (result !== exps[got]) begin n_fail++; $display("FAIL b2b_result%0d: got %h, expected %h", got, result, exps[got]); end
          n_checks++;
          if (flags !== 3'b000) begin n_fail++; $display("FAIL b2b_flags%0d: got %b, expected 000", got, flags); end
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (got !== 5) begin n_fail++; $display("FAIL b2b_result_count: got %0d, expected 5", got); end
    n_checks++;
    if (sent !== 5) begin n_fail++; $display("FAIL b2b_accept_count: got %0d, expected 5", sent); end
  endtask

  task automatic test_reset_midstream;
    int stale;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'h40000000; b = 32'h3F800000; op = 1'b0;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_out_valid: got %b, expected 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_async_out_valid: got %b, expected 0", out_valid); end
    n_checks++;
    if (result !== 32'h0) begin n_fail++; $display("FAIL midrst_result: got %h, expected 00000000", result); end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    stale     = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) stale++;
    end
    n_checks++;
    if (stale !== 0) begin n_fail++; $display("FAIL midrst_stale_results: got %0d, expected 0", stale); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b, expected 1", in_ready); end
  endtask

  task automatic test_double;
    int lat;
    logic got;
    logic [63:0] r;
    logic [2:0]  f;
    lat = 0; got = 1'b0; r = '0; f = '0;
    @(negedge clk);
    d_in_valid = 1'b1; d_a = 64'h3FF0000000000000; d_b = 64'h4000000000000000; d_op = 1'b0;
    @(posedge clk);
    #1 d_in_valid = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (d_out_valid) begin got = 1'b1; r = d_result; f = d_flags; end
    end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL dp_latency: got %0d, expected 3", lat); end
    n_checks++;
    if (r !== 64'h4008000000000000) begin n_fail++; $display("FAIL dp_result: got %h, expected 4008000000000000", r); end
    n_checks++;
    if (f !== 3'b000) begin n_fail++; $display("FAIL dp_flags: got %b, expected 000", f); end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_zero_results();
    test_specials();
    test_overflow();
    test_rounding();
    test_back_to_back();
    test_reset_midstream();
    test_double();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
